// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch front end: owns the PC, fetches over ready/valid, holds the word for decode.
// Build option MISALIGN_TRAP_EN: a misaligned next PC traps into a sticky FAULT state instead of being truncated.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        stall,
  output logic        fault
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
`endif

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic        instr_valid_r, instr_valid_s;
  logic        imem_req_r, imem_req_s;
  logic [31:0] target_s;
`ifdef MISALIGN_TRAP_EN
  logic        fault_r, fault_s;
`endif

  // Next-PC candidate selected by the decoder code; bit 0 of a jalr target is always cleared.
  always_comb begin
    target_s = pc_r + 32'd4;
    case (pc_src)
      2'b01:   target_s = pc_r + imm_ext;
      2'b10:   target_s = alu_result & 32'hFFFF_FFFE;
      default: target_s = pc_r + 32'd4;
    endcase
  end

  // Next-state and next-register-value logic for the fetch FSM.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    instr_s       = instr_r;
    instr_valid_s = instr_valid_r;
`ifdef MISALIGN_TRAP_EN
    fault_s       = fault_r;
`endif
    case (state_r)
      ST_FETCH: begin
        if (imem_req_r && imem_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        // A response in the acceptance cycle is impossible here: we are still in FETCH then.
        if (imem_rvalid) begin
          instr_s       = imem_rdata;
          instr_valid_s = 1'b1;
          state_s       = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (retire) begin
          instr_s       = NOP_INSTR;
          instr_valid_s = 1'b0;
`ifdef MISALIGN_TRAP_EN
          pc_s = target_s;
          if (target_s[1:0] != 2'b00) begin
            fault_s = 1'b1;
            state_s = ST_FAULT;
          end else begin
            state_s = ST_FETCH;
          end
`else
          pc_s    = target_s & 32'hFFFF_FFFC;
          state_s = ST_FETCH;
`endif
        end else begin
          state_s = ST_HOLD;
        end
      end
`ifdef MISALIGN_TRAP_EN
      ST_FAULT: begin
        fault_s       = 1'b1;
        instr_s       = NOP_INSTR;
        instr_valid_s = 1'b0;
        state_s       = ST_FAULT;
      end
`endif
      default: begin
        instr_s       = NOP_INSTR;
        instr_valid_s = 1'b0;
        state_s       = ST_FETCH;
      end
    endcase
    // Request is a registered copy of "next state is FETCH", so it is glitch-free and held until accepted.
    imem_req_s = (state_s == ST_FETCH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC;
      instr_r       <= NOP_INSTR;
      instr_valid_r <= 1'b0;
      imem_req_r    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      fault_r       <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      instr_r       <= instr_s;
      instr_valid_r <= instr_valid_s;
      imem_req_r    <= imem_req_s;
`ifdef MISALIGN_TRAP_EN
      fault_r       <= fault_s;
`endif
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + 32'd4;
  assign stall       = ~instr_valid_r;
`ifdef MISALIGN_TRAP_EN
  assign fault       = fault_r;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a driver plays memory and retire stimulus and
// feeds an architectural PC model; a negedge monitor pops expectations and compares.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          N_CYC     = 3000;
  localparam int          MID_RST   = 1500;
  localparam int          TAIL_CYC  = 2500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm_ext = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic        retire = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        fault;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .imm_ext(imm_ext), .alu_result(alu_result),
    .retire(retire), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_instr_t;
  typedef struct packed { logic [1:0] src; logic [31:0] imm; logic [31:0] alu; } ret_t;

  logic [31:0] exp_addr_q[$];
  exp_instr_t  exp_instr_q[$];
  ret_t        head_q[$];
  ret_t        tail_q[$];

  // architectural model state, owned by the driver
  logic [31:0] model_pc = RESET_PC;
  logic        model_held = 1'b0;
  logic        model_fault = 1'b0;
  logic        outstanding = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int delivered = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Monitor: decoupled from the driver, compares DUT outputs against queued and modelled expectations.
  logic        rst_prev = 1'b0;
  logic        valid_prev = 1'b0;
  logic [31:0] held_exp = 32'd0;
  exp_instr_t  e;
  logic [31:0] a;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rst_prev) begin
          chk("reset pc", pc, RESET_PC);
          chk("reset instr", instr, NOP_INSTR);
          chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
          chk("reset imem_req", {31'd0, imem_req}, 32'd0);
          chk("reset fault", {31'd0, fault}, 32'd0);
        end
        rst_prev   = 1'b1;
        valid_prev = 1'b0;
      end else begin
        rst_prev = 1'b0;
        if (imem_req && imem_ready) begin
          if (exp_addr_q.size() == 0) begin
            fail_event("unexpected request", imem_addr);
          end else begin
            a = exp_addr_q.pop_front();
            chk("fetch addr", imem_addr, a);
          end
        end
        if (instr_valid && !valid_prev) begin
          if (exp_instr_q.size() == 0) begin
            fail_event("unexpected instr", instr);
          end else begin
            e = exp_instr_q.pop_front();
            held_exp = e.word;
            delivered++;
            chk("instr word", instr, e.word);
          end
        end else if (instr_valid && valid_prev) begin
          chk("instr stable", instr, held_exp);
        end
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, model_held});
        chk("stall", {31'd0, stall}, {31'd0, ~model_held});
        chk("pc", pc, model_pc);
        chk("pc_plus4", pc_plus4, model_pc + 32'd4);
        chk("fault", {31'd0, fault}, {31'd0, model_fault});
        if (!model_held) chk("nop when empty", instr, NOP_INSTR);
        if (outstanding || model_held || model_fault) chk("req idle", {31'd0, imem_req}, 32'd0);
        valid_prev = instr_valid;
      end
    end
  end

  // Driver: memory responder, retire stimulus and reference model update.
  initial begin
    logic        hs, rv_ok, ret_ok, mid_done;
    logic [31:0] acc_addr, t;
    int          lat, rst_cnt;
    ret_t        r;
    hs = 1'b0; rv_ok = 1'b0; ret_ok = 1'b0; mid_done = 1'b0;
    acc_addr = 32'd0; lat = 0; rst_cnt = 3;
    head_q.push_back('{2'b00, 32'd0,          32'd0});
    head_q.push_back('{2'b10, 32'd0,          32'h0000_0010});
    head_q.push_back('{2'b01, 32'hFFFF_FFF8,  32'd0});
    head_q.push_back('{2'b10, 32'd0,          32'h0000_0105});
    head_q.push_back('{2'b10, 32'd0,          32'h0000_0020});
    head_q.push_back('{2'b11, 32'h1234_5670,  32'd0});
    head_q.push_back('{2'b10, 32'd0,          32'hFFFF_FFFD});
    head_q.push_back('{2'b00, 32'd0,          32'd0});
    tail_q.push_back('{2'b10, 32'd0,          32'h0000_0000});
    tail_q.push_back('{2'b01, 32'h0000_0002,  32'd0});

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      hs     = imem_req && imem_ready && !reset;
      rv_ok  = imem_rvalid && outstanding && !reset;
      ret_ok = retire && model_held && !reset;
      if (hs) acc_addr = imem_addr;
      @(posedge clk);
      #1;
      if (hs) begin
        outstanding = 1'b1;
        lat = $urandom_range(0, 4);
      end
      if (rv_ok) begin
        outstanding = 1'b0;
        model_held  = 1'b1;
        exp_instr_q.push_back('{model_pc, mem_word(model_pc)});
      end
      if (ret_ok) begin
        model_held = 1'b0;
        case (pc_src)
          2'b01:   t = model_pc + imm_ext;
          2'b10:   t = alu_result & 32'hFFFF_FFFE;
          default: t = model_pc + 32'd4;
        endcase
`ifdef MISALIGN_TRAP_EN
        model_pc = t;
        if (t % 4 != 0) model_fault = 1'b1;
        else exp_addr_q.push_back(t);
`else
        model_pc = t & 32'hFFFF_FFFC;
        exp_addr_q.push_back(model_pc);
`endif
      end
      if (!mid_done && cyc > MID_RST && outstanding) begin
        mid_done = 1'b1;
        rst_cnt  = 2;
      end
      if (rst_cnt > 0) begin
        rst_cnt--;
        reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;
        model_pc = RESET_PC; model_held = 1'b0; model_fault = 1'b0; outstanding = 1'b0;
        exp_addr_q.delete();
        exp_addr_q.push_back(RESET_PC);
        continue;
      end
      reset = 1'b0;
      imem_ready = ($urandom_range(0, 3) != 0);
      if (outstanding) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(acc_addr);
        end else begin
          lat--;
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom;
        end
      end else begin
        imem_rvalid = ($urandom_range(0, 5) == 0);
        imem_rdata  = $urandom;
      end
      if (model_held && ($urandom_range(0, 2) != 0)) begin
        retire = 1'b1;
        if (head_q.size() > 0) r = head_q.pop_front();
        else if (cyc >= TAIL_CYC && tail_q.size() > 0) r = tail_q.pop_front();
        else begin
          r.src = 2'($urandom_range(0, 3));
`ifdef MISALIGN_TRAP_EN
          r.imm = $urandom & 32'hFFFF_FFFC;
          r.alu = $urandom & 32'hFFFF_FFFD;
`else
          r.imm = $urandom;
          r.alu = $urandom;
`endif
        end
        pc_src = r.src; imm_ext = r.imm; alu_result = r.alu;
      end else begin
        retire     = !model_held && ($urandom_range(0, 7) == 0);
        pc_src     = 2'($urandom_range(0, 3));
        imm_ext    = $urandom;
        alu_result = $urandom;
      end
    end
    @(negedge clk);
    chk("progress", delivered >= 20 ? 32'd1 : 32'd0, 32'd1);
`ifdef MISALIGN_TRAP_EN
    chk("trap reached", {31'd0, fault}, 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
